// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct constants, instruction field positions and branch-target helper
package mips_pkg;
    localparam logic [5:0]  OP_RTYPE  = 6'b000000;
    localparam logic [5:0]  OP_LW     = 6'b100011;
    localparam logic [5:0]  OP_SW     = 6'b101011;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  F_ADD     = 6'b100000;
    localparam logic [5:0]  F_SUB     = 6'b100010;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam int          OPCODE_LSB = 26;
    localparam int          RS_LSB     = 21;
    localparam int          RT_LSB     = 16;
    localparam int          RD_LSB     = 11;
    localparam int          FUNCT_LSB  = 0;
    localparam int          IMM_LSB    = 0;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4, input logic [31:0] offset);
        return pc_plus4 + (offset << 2);
    endfunction
endpackage

// File: rtl/instr_mem.sv
// instr_mem: word-addressed instruction store with asynchronous read and synchronous write
module instr_mem
    import mips_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

    assign rdata = mem[raddr];

    // load port: a same-edge fetch still sees the old word because the read is taken before this update lands
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, instruction memory and IF/ID register with branch redirect, stall and flush
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [31:0]       br_pc_plus4,
    input  logic [31:0]       br_offset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [15:0]       imm
);
    logic        branch_taken;
    logic [31:0] pc_plus4;
    logic [31:0] fetched;

    assign branch_taken = Branch & Zero;
    assign pc_plus4     = pc + 32'd4;

    instr_mem #(.DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (fetched)
    );

    // PC and IF/ID register: a taken branch redirects and flushes even while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (branch_taken) begin
            pc             <= branch_target(br_pc_plus4, br_offset);
            if_id_instr    <= NOP_WORD;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            pc             <= pc_plus4;
            if_id_instr    <= fetched;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

    assign opcode = if_id_instr[OPCODE_LSB +: 6];
    assign rs     = if_id_instr[RS_LSB +: 5];
    assign rt     = if_id_instr[RT_LSB +: 5];
    assign rd     = if_id_instr[RD_LSB +: 5];
    assign funct  = if_id_instr[FUNCT_LSB +: 6];
    assign imm    = if_id_instr[IMM_LSB +: 16];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench with a behavioural fetch model, directed plan items and random traffic
module tb_instruction_fetch;
    import mips_pkg::*;
    localparam int DEPTH = 256;

    logic        clk = 0, reset = 1, stall = 0, Branch = 0, Zero = 0, imem_we = 0;
    logic [31:0] br_pc_plus4 = 0, br_offset = 0, imem_wdata = 0;
    logic [7:0]  imem_waddr = 0;
    logic [31:0] pc, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    instruction_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .Branch(Branch), .Zero(Zero),
        .br_pc_plus4(br_pc_plus4), .br_offset(br_offset), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, instr, pc4;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0, n_tot = 0;
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc = 0, m_instr = 0, m_pc4 = 0;
    logic        m_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // one clock edge of the reference model using the currently driven inputs, then advance to the next negedge
    task automatic cyc();
        exp_t e;
        if (!reset) begin
            if (Branch && Zero) begin
                m_pc    = br_pc_plus4 + br_offset * 4;
                m_instr = 0;
                m_pc4   = 0;
                m_valid = 0;
            end else if (!stall) begin
                m_instr = m_mem[(m_pc / 4) % DEPTH];
                m_pc4   = m_pc + 4;
                m_pc    = m_pc + 4;
                m_valid = 1;
            end
            e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
            sb.push_back(e);
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
        @(negedge clk);
    endtask

    task automatic take(input logic [31:0] p4, input logic [31:0] off);
        Branch = 1; Zero = 1; br_pc_plus4 = p4; br_offset = off;
        cyc();
        Branch = 0; Zero = 0;
    endtask

    // monitor: compare every registered output against the oldest expected entry just after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
            chk("opcode", {26'b0, opcode}, e.instr >> 26);
            chk("rs", {27'b0, rs}, (e.instr >> 21) & 31);
            chk("rt", {27'b0, rt}, (e.instr >> 16) & 31);
            chk("rd", {27'b0, rd}, (e.instr >> 11) & 31);
            chk("funct", {26'b0, funct}, e.instr & 63);
            chk("imm", {16'b0, imm}, e.instr & 32'hFFFF);
        end
    end

    initial begin
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_instr", if_id_instr, 0);
        chk("reset_pc4", if_id_pc_plus4, 0);
        chk("reset_valid", {31'b0, if_id_valid}, 0);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1; imem_waddr = 8'(i);
            imem_wdata = i == 0 ? 32'h0000_0020 : i == 1 ? 32'h8C00_0000 :
                         i == 2 ? 32'h1000_0002 : i == 3 ? 32'h0000_0022 : $urandom;
            cyc();
        end
        imem_we = 0;
        chk("held_reset_pc", pc, 0);
        reset = 0;
        cyc();
        chk("add_opcode", {26'b0, opcode}, {26'b0, OP_RTYPE});
        chk("add_funct", {26'b0, funct}, {26'b0, F_ADD});
        cyc();
        chk("lw_opcode", {26'b0, opcode}, {26'b0, OP_LW});
        stall = 1;
        cyc(); cyc();
        chk("stall_pc", pc, 8);
        chk("stall_instr", if_id_instr, 32'h8C00_0000);
        chk("stall_valid", {31'b0, if_id_valid}, 1);
        stall = 0;
        cyc();
        chk("beq_opcode", {26'b0, opcode}, {26'b0, OP_BEQ});
        take(12, 2);
        chk("taken_pc", pc, 20);
        chk("taken_flush", if_id_instr, 0);
        cyc();
        chk("target_fetch", if_id_instr, m_mem[5]);
        Branch = 1; Zero = 0;
        cyc();
        Branch = 0;
        chk("not_taken_pc", pc, 28);
        stall = 1;
        take(100, 32'hFFFF_FFFF);
        stall = 0;
        chk("taken_over_stall_pc", pc, 96);
        chk("taken_over_stall_valid", {31'b0, if_id_valid}, 0);
        take(4, 0);
        imem_we = 1; imem_waddr = 1; imem_wdata = 32'hDEAD_BEEF;
        cyc();
        imem_we = 0;
        chk("same_edge_old_word", if_id_instr, 32'h8C00_0000);
        take(4, 0);
        cyc();
        chk("refetch_new_word", if_id_instr, 32'hDEAD_BEEF);
        take(4 * DEPTH, 0);
        cyc();
        chk("index_wrap", if_id_instr, 32'h0000_0020);
        take(14, 0);
        cyc();
        chk("misaligned_fetch", if_id_instr, 32'h0000_0022);
        chk("misaligned_pc4", if_id_pc_plus4, 18);
        take(32'hFFFF_FFFC, 0);
        cyc();
        chk("pc_wrap", pc, 0);
        chk("pc4_wrap", if_id_pc_plus4, 0);
        for (int i = 0; i < 600; i++) begin
            stall = $urandom_range(3) == 0;
            Branch = $urandom_range(4) == 0;
            Zero = $urandom_range(1) == 1;
            br_pc_plus4 = $urandom_range(1) == 1 ? $urandom : $urandom_range(2047);
            r = $urandom;
            br_offset = {{16{r[15]}}, r[15:0]};
            imem_we = $urandom_range(2) == 0;
            imem_waddr = 8'($urandom);
            imem_wdata = $urandom;
            cyc();
        end
        stall = 0; Branch = 0; Zero = 0; imem_we = 0;
        #2 reset = 1;
        #1;
        chk("async_reset_pc", pc, 0);
        chk("async_reset_instr", if_id_instr, 0);
        chk("async_reset_pc4", if_id_pc_plus4, 0);
        chk("async_reset_valid", {31'b0, if_id_valid}, 0);
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        @(negedge clk);
        reset = 0;
        cyc();
        chk("post_reset_pc", pc, 4);
        chk("post_reset_fetch", if_id_instr, m_mem[0]);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
